aes_key_expander: RTL

//  Iterative AES-128 key schedule. Expands a 128-bit cipher key into 11 round keys, one per clock,
//  and stores them in a register file. Serves the AddRoundKey stage that sits directly ahead of

---
 rtl/aes_pkg.sv | 41 ++++
 rtl/aes_sub_word.sv | 12 +
 rtl/aes_key_expander.sv | 127 ++++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions: forward S-box, GF(2^8) doubling, AES-128 sizing and
// the key-expander state encoding.
package aes_pkg;

    localparam int NR = 10;
    localparam int NK = 4;
    localparam logic [7:0] RCON_INIT = 8'h01;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_EXPAND = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    // Entry 0x00 sits in the top byte so the table reads like the FIPS-197 figure.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX_TABLE[11'd2047 - {x, 3'b000} -: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_sub_word.sv
// Combinational SubWord: four independent forward S-box lookups on a 32-bit word.
module aes_sub_word
    import aes_pkg::*;
(
    input  logic [31:0] i_word,
    output logic [31:0] o_word
);

    assign o_word = {sbox(i_word[31:24]), sbox(i_word[23:16]),
                     sbox(i_word[15:8]),  sbox(i_word[7:0])};

endmodule

// File: rtl/aes_key_expander.sv
// Iterative AES-128 key schedule: one round key per clock into an 11-entry
// register file, with a registered random-access read port.
module aes_key_expander
    import aes_pkg::*;
#(
    parameter int IDX_W = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [32*NK-1:0]    key_in,
    output logic                busy,
    output logic                done,
    output logic                keys_valid,
    input  logic [IDX_W-1:0]    rk_idx,
    output logic [32*NK-1:0]    rk_out,
    output logic [1:0]          o_dbg_state
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NR);

    logic [1:0]         r_state;
    logic [IDX_W-1:0]   r_cnt;
    logic [7:0]         r_rcon;
    logic               r_busy;
    logic               r_done;
    logic               r_keys_valid;
    logic [32*NK-1:0]   r_rk [0:NR];
    logic [32*NK-1:0]   r_rk_out;

    logic [IDX_W-1:0]   w_prev_idx;
    logic [32*NK-1:0]   w_prev;
    logic [31:0]        w_rot;
    logic [31:0]        w_sub;
    logic [31:0]        w_t;
    logic [31:0]        w_n0, w_n1, w_n2, w_n3;
    logic               w_accept;

    assign w_accept = (r_state == ST_IDLE) && start;

    // The previous round key is always the entry just below the write pointer.
    always_comb begin
        w_prev_idx = r_cnt - 1'b1;
        w_prev     = '0;
        if (w_prev_idx <= LAST_IDX) begin
            w_prev = r_rk[w_prev_idx];
        end
    end

    assign w_rot = {w_prev[23:0], w_prev[31:24]};

    aes_sub_word u_sub_word (
        .i_word (w_rot),
        .o_word (w_sub)
    );

    assign w_t  = w_sub ^ {r_rcon, 24'h0};
    assign w_n0 = w_prev[127:96] ^ w_t;
    assign w_n1 = w_prev[95:64]  ^ w_n0;
    assign w_n2 = w_prev[63:32]  ^ w_n1;
    assign w_n3 = w_prev[31:0]   ^ w_n2;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_rcon       <= RCON_INIT;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_keys_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_rcon       <= RCON_INIT;
                        r_cnt        <= IDX_W'(1);
                        r_busy       <= 1'b1;
                        r_keys_valid <= 1'b0;
                        r_state      <= ST_EXPAND;
                    end
                end
                ST_EXPAND: begin
                    r_rcon <= xtime(r_rcon);
                    if (r_cnt == LAST_IDX) begin
                        r_busy       <= 1'b0;
                        r_done       <= 1'b1;
                        r_keys_valid <= 1'b1;
                        r_state      <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Key storage is deliberately not cleared; keys_valid tells consumers when it is usable.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (w_accept) begin
                r_rk[0] <= key_in;
            end else if (r_state == ST_EXPAND) begin
                r_rk[r_cnt] <= {w_n0, w_n1, w_n2, w_n3};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rk_out <= '0;
        end else begin
            r_rk_out <= (rk_idx <= LAST_IDX) ? r_rk[rk_idx] : '0;
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign keys_valid  = r_keys_valid;
    assign rk_out      = r_rk_out;
    assign o_dbg_state = r_state;

endmodule
